// File: rtl/alu_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_stage
// Description : MIPS ALU-control decode stage. Decodes a 32-bit instruction
//               into an ALU operation code, shift amount and extended
//               immediate. Results are registered with one cycle of latency.
//               Illegal instructions are counted and flagged; optionally
//               the stage halts until cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_stage #(
    parameter int STICKY_ILLEGAL = 1
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_Valid,
    input  logic [31:0] i_Instruction,
    input  logic        i_Stall,
    input  logic        i_Flush,
    input  logic        i_Clear,
    output logic        o_Valid,
    output logic [3:0]  o_ALU_Control,
    output logic [4:0]  o_Shamt,
    output logic        o_Use_Imm,
    output logic [31:0] o_Imm_Ext,
    output logic        o_Error,
    output logic [7:0]  o_Illegal_Count
);

    // ALU operation codes
    localparam logic [3:0] c_ALU_SLL    = 4'd0;
    localparam logic [3:0] c_ALU_SRL    = 4'd1;
    localparam logic [3:0] c_ALU_SRA    = 4'd2;
    localparam logic [3:0] c_ALU_SLLV   = 4'd3;
    localparam logic [3:0] c_ALU_SRLV   = 4'd4;
    localparam logic [3:0] c_ALU_SRAV   = 4'd5;
    localparam logic [3:0] c_ALU_ADDU   = 4'd6;
    localparam logic [3:0] c_ALU_SUBU   = 4'd7;
    localparam logic [3:0] c_ALU_AND    = 4'd8;
    localparam logic [3:0] c_ALU_OR     = 4'd9;
    localparam logic [3:0] c_ALU_XOR    = 4'd10;
    localparam logic [3:0] c_ALU_NOR    = 4'd11;
    localparam logic [3:0] c_ALU_SLT    = 4'd12;
    localparam logic [3:0] c_ALU_JALR   = 4'd13;
    localparam logic [3:0] c_ALU_LUI    = 4'd14;
    localparam logic [3:0] c_ALU_BUBBLE = 4'd15;

    // FSM encoding
    localparam logic [0:0] c_ST_RUN  = 1'b0;
    localparam logic [0:0] c_ST_HALT = 1'b1;

    localparam logic c_STICKY = (STICKY_ILLEGAL != 0);

    // Instruction fields
    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [31:0] w_sext;
    logic [31:0] w_zext;
    logic        w_unused_fields;

    assign w_opcode        = i_Instruction[31:26];
    assign w_funct         = i_Instruction[5:0];
    assign w_imm           = i_Instruction[15:0];
    assign w_sext          = {{16{w_imm[15]}}, w_imm};
    assign w_zext          = {16'h0000, w_imm};
    // rs/rt register fields are not needed to pick the ALU operation
    assign w_unused_fields = ^i_Instruction[25:16];

    // Decode results
    logic        w_legal;
    logic [3:0]  w_alu;
    logic        w_use_imm;
    logic [31:0] w_imm_ext;

    // State and registered outputs
    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic        r_valid;
    logic [3:0]  r_alu;
    logic [4:0]  r_shamt;
    logic        r_use_imm;
    logic [31:0] r_imm_ext;
    logic        r_error;
    logic [7:0]  r_count;

    // Next-cycle values
    logic        w_valid_next;
    logic [3:0]  w_alu_next;
    logic [4:0]  w_shamt_next;
    logic        w_use_imm_next;
    logic [31:0] w_imm_ext_next;
    logic        w_error_next;
    logic [7:0]  w_count_next;

    // Control qualifiers; flush beats stall beats clear beats decode
    logic w_ctrl_free;
    logic w_take;
    logic w_accept_legal;
    logic w_accept_illegal;
    logic w_out_update;

    assign w_ctrl_free      = !i_Flush && !i_Stall;
    assign w_take           = w_ctrl_free && !i_Clear && (r_state == c_ST_RUN) && i_Valid;
    assign w_accept_legal   = w_take && w_legal;
    assign w_accept_illegal = w_take && !w_legal;
    // A stall freezes the output registers unless a flush overrides it
    assign w_out_update     = i_Flush || !i_Stall;

    // Combinational instruction decoder
    always_comb begin
        w_legal   = 1'b1;
        w_alu     = c_ALU_BUBBLE;
        w_use_imm = 1'b0;
        w_imm_ext = w_sext;
        case (w_opcode)
            6'b000000: begin
                case (w_funct)
                    6'b000000: w_alu = c_ALU_SLL;
                    6'b000010: w_alu = c_ALU_SRL;
                    6'b000011: w_alu = c_ALU_SRA;
                    6'b000100: w_alu = c_ALU_SLLV;
                    6'b000110: w_alu = c_ALU_SRLV;
                    6'b000111: w_alu = c_ALU_SRAV;
                    6'b100001: w_alu = c_ALU_ADDU;
                    6'b100011: w_alu = c_ALU_SUBU;
                    6'b100100: w_alu = c_ALU_AND;
                    6'b100101: w_alu = c_ALU_OR;
                    6'b100110: w_alu = c_ALU_XOR;
                    6'b100111: w_alu = c_ALU_NOR;
                    6'b101010: w_alu = c_ALU_SLT;
                    6'b001001: w_alu = c_ALU_JALR;
                    default:   w_legal = 1'b0;
                endcase
            end
            // ADDI, ADDIU, LW, SW: address / add with sign-extended imm
            6'b001000, 6'b001001, 6'b100011, 6'b101011: begin
                w_alu     = c_ALU_ADDU;
                w_use_imm = 1'b1;
            end
            6'b001010: begin
                w_alu     = c_ALU_SLT;
                w_use_imm = 1'b1;
            end
            6'b001100: begin
                w_alu     = c_ALU_AND;
                w_use_imm = 1'b1;
                w_imm_ext = w_zext;
            end
            6'b001101: begin
                w_alu     = c_ALU_OR;
                w_use_imm = 1'b1;
                w_imm_ext = w_zext;
            end
            6'b001110: begin
                w_alu     = c_ALU_XOR;
                w_use_imm = 1'b1;
                w_imm_ext = w_zext;
            end
            // LUI passes the raw imm; the ALU performs the 16-bit shift
            6'b001111: begin
                w_alu     = c_ALU_LUI;
                w_use_imm = 1'b1;
                w_imm_ext = w_zext;
            end
            // BEQ/BNE compare rs-rt; the offset is carried for the branch unit
            6'b000100, 6'b000101: begin
                w_alu = c_ALU_SUBU;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (w_ctrl_free) begin
            if (i_Clear) begin
                w_state_next = c_ST_RUN;
            end else if (w_accept_illegal && c_STICKY) begin
                w_state_next = c_ST_HALT;
            end
        end
    end

    // Output logic: next values for the output, error and counter registers
    always_comb begin
        w_valid_next   = 1'b0;
        w_alu_next     = c_ALU_BUBBLE;
        w_shamt_next   = 5'd0;
        w_use_imm_next = 1'b0;
        w_imm_ext_next = 32'h0000_0000;
        w_error_next   = r_error;
        w_count_next   = r_count;
        if (w_accept_legal) begin
            w_valid_next   = 1'b1;
            w_alu_next     = w_alu;
            w_shamt_next   = i_Instruction[10:6];
            w_use_imm_next = w_use_imm;
            w_imm_ext_next = w_imm_ext;
        end
        if (w_ctrl_free && i_Clear) begin
            w_error_next = 1'b0;
        end else if (w_accept_illegal) begin
            w_error_next = 1'b1;
            if (r_count != 8'hFF) begin
                w_count_next = r_count + 8'd1;
            end
        end
    end

    // Output, error and counter registers
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_valid   <= 1'b0;
            r_alu     <= c_ALU_BUBBLE;
            r_shamt   <= 5'd0;
            r_use_imm <= 1'b0;
            r_imm_ext <= 32'h0000_0000;
            r_error   <= 1'b0;
            r_count   <= 8'd0;
        end else begin
            if (w_out_update) begin
                r_valid   <= w_valid_next;
                r_alu     <= w_alu_next;
                r_shamt   <= w_shamt_next;
                r_use_imm <= w_use_imm_next;
                r_imm_ext <= w_imm_ext_next;
            end
            r_error <= w_error_next;
            r_count <= w_count_next;
        end
    end

    assign o_Valid         = r_valid;
    assign o_ALU_Control   = r_alu;
    assign o_Shamt         = r_shamt;
    assign o_Use_Imm       = r_use_imm;
    assign o_Imm_Ext       = r_imm_ext;
    assign o_Error         = r_error;
    assign o_Illegal_Count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_stage
// Description : Self-checking bench for alu_ctrl_stage. Two instances share
//               stimulus: one halting on illegal instructions, one that only
//               flags them. Expected results go through per-instance queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_stage;

    typedef struct packed {
        logic        valid;
        logic [3:0]  alu;
        logic [4:0]  shamt;
        logic        use_imm;
        logic [31:0] imm;
        logic        chk_imm;
        logic        err;
        logic [7:0]  cnt;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        exp_t        exp;
    } vec_t;

    localparam logic [31:0] c_ADDU    = 32'h0085_1021;
    localparam logic [31:0] c_SRA     = 32'h0004_1083;
    localparam logic [31:0] c_ILLEGAL = 32'hFC00_0000;
    localparam int          c_NVEC    = 24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        clear = 1'b0;

    logic        a_valid, b_valid;
    logic [3:0]  a_alu, b_alu;
    logic [4:0]  a_shamt, b_shamt;
    logic        a_use_imm, b_use_imm;
    logic [31:0] a_imm, b_imm;
    logic        a_err, b_err;
    logic [7:0]  a_cnt, b_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    vec_t vecs[c_NVEC];

    alu_ctrl_stage #(.STICKY_ILLEGAL(1)) u_dut_sticky (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Valid(valid), .i_Instruction(instr),
        .i_Stall(stall), .i_Flush(flush), .i_Clear(clear),
        .o_Valid(a_valid), .o_ALU_Control(a_alu), .o_Shamt(a_shamt),
        .o_Use_Imm(a_use_imm), .o_Imm_Ext(a_imm), .o_Error(a_err),
        .o_Illegal_Count(a_cnt)
    );

    alu_ctrl_stage #(.STICKY_ILLEGAL(0)) u_dut_flag (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Valid(valid), .i_Instruction(instr),
        .i_Stall(stall), .i_Flush(flush), .i_Clear(clear),
        .o_Valid(b_valid), .o_ALU_Control(b_alu), .o_Shamt(b_shamt),
        .o_Use_Imm(b_use_imm), .o_Imm_Ext(b_imm), .o_Error(b_err),
        .o_Illegal_Count(b_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic v, input logic [3:0] alu, input logic [4:0] sh,
                                input logic ui, input logic [31:0] imm, input logic ci,
                                input logic e, input logic [7:0] c);
        exp_t r;
        r.valid = v; r.alu = alu; r.shamt = sh; r.use_imm = ui;
        r.imm = imm; r.chk_imm = ci; r.err = e; r.cnt = c;
        return r;
    endfunction

    function automatic exp_t bub(input logic e, input logic [7:0] c);
        return mk(1'b0, 4'd15, 5'd0, 1'b0, 32'h0, 1'b1, e, c);
    endfunction

    function automatic exp_t actual(input int k);
        if (k == 0)
            return mk(a_valid, a_alu, a_shamt, a_use_imm, a_imm, 1'b1, a_err, a_cnt);
        return mk(b_valid, b_alu, b_shamt, b_use_imm, b_imm, 1'b1, b_err, b_cnt);
    endfunction

    // Pop the oldest expectation for instance k and compare it to the outputs
    task automatic chk(input int k, input string name);
        exp_t e;
        exp_t a;
        logic ok;
        n_checks++;
        if ((k == 0 && q_a.size() == 0) || (k != 0 && q_b.size() == 0)) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty for instance %0d", name, k);
            return;
        end
        e = (k == 0) ? q_a.pop_front() : q_b.pop_front();
        a = actual(k);
        ok = (a.valid == e.valid) && (a.alu == e.alu) && (a.shamt == e.shamt) &&
             (a.use_imm == e.use_imm) && (a.err == e.err) && (a.cnt == e.cnt) &&
             (!e.chk_imm || (a.imm == e.imm));
        if (!ok) begin
            n_fail++;
            $display("FAIL %s[%0d]: actual v=%0b alu=%0d sh=%0d ui=%0b imm=%08h err=%0b cnt=%0d required v=%0b alu=%0d sh=%0d ui=%0b imm=%08h(chk=%0b) err=%0b cnt=%0d",
                     name, k, a.valid, a.alu, a.shamt, a.use_imm, a.imm, a.err, a.cnt,
                     e.valid, e.alu, e.shamt, e.use_imm, e.imm, e.chk_imm, e.err, e.cnt);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic st,
                         input logic fl, input logic cl);
        valid = v; instr = ins; stall = st; flush = fl; clear = cl;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse placed between clock edges; outputs must react immediately
    task automatic reset_pulse(input string name);
        rst_n = 1'b0;
        #1;
        q_a.push_back(bub(1'b0, 8'd0));
        q_b.push_back(bub(1'b0, 8'd0));
        chk(0, name);
        chk(1, name);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Table: legal instructions; error stays 0, count stays 0
        vecs[0]  = '{c_ADDU,        mk(1, 4'd6,  5'd0,  0, 32'h0,        0, 0, 8'd0)};
        vecs[1]  = '{32'h2084_FFFF, mk(1, 4'd6,  5'd31, 1, 32'hFFFF_FFFF, 1, 0, 8'd0)};
        vecs[2]  = '{32'h3484_FFFF, mk(1, 4'd9,  5'd31, 1, 32'h0000_FFFF, 1, 0, 8'd0)};
        vecs[3]  = '{c_SRA,         mk(1, 4'd2,  5'd2,  0, 32'h0,        0, 0, 8'd0)};
        vecs[4]  = '{32'h3C01_1234, mk(1, 4'd14, 5'd8,  1, 32'h0000_1234, 1, 0, 8'd0)};
        vecs[5]  = '{32'h2822_FFF0, mk(1, 4'd12, 5'd31, 1, 32'hFFFF_FFF0, 1, 0, 8'd0)};
        vecs[6]  = '{32'h1022_0004, mk(1, 4'd7,  5'd0,  0, 32'h0000_0004, 1, 0, 8'd0)};
        vecs[7]  = '{32'h8C22_0008, mk(1, 4'd6,  5'd0,  1, 32'h0000_0008, 1, 0, 8'd0)};
        vecs[8]  = '{32'hAC22_FFFC, mk(1, 4'd6,  5'd31, 1, 32'hFFFF_FFFC, 1, 0, 8'd0)};
        vecs[9]  = '{32'h3022_FF00, mk(1, 4'd8,  5'd28, 1, 32'h0000_FF00, 1, 0, 8'd0)};
        vecs[10] = '{32'h3822_0001, mk(1, 4'd10, 5'd0,  1, 32'h0000_0001, 1, 0, 8'd0)};
        vecs[11] = '{32'h0022_1827, mk(1, 4'd11, 5'd0,  0, 32'h0,        0, 0, 8'd0)};
        vecs[12] = '{32'h0022_182A, mk(1, 4'd12, 5'd0,  0, 32'h0,        0, 0, 8'd0)};
        vecs[13] = '{32'h0020_0009, mk(1, 4'd13, 5'd0,  0, 32'h0,        0, 0, 8'd0)};
        vecs[14] = '{32'h0022_1804, mk(1, 4'd3,  5'd0,  0, 32'h0,        0, 0, 8'd0)};
        vecs[15] = '{32'h0022_1806, mk(1, 4'd4,  5'd0,  0, 32'h0,        0, 0, 8'd0)};
        vecs[16] = '{32'h0022_1807, mk(1, 4'd5,  5'd0,  0, 32'h0,        0, 0, 8'd0)};
        vecs[17] = '{32'h0001_1100, mk(1, 4'd0,  5'd4,  0, 32'h0,        0, 0, 8'd0)};
        vecs[18] = '{32'h0001_1142, mk(1, 4'd1,  5'd5,  0, 32'h0,        0, 0, 8'd0)};
        vecs[19] = '{32'h0022_1823, mk(1, 4'd7,  5'd0,  0, 32'h0,        0, 0, 8'd0)};
        vecs[20] = '{32'h0022_1824, mk(1, 4'd8,  5'd0,  0, 32'h0,        0, 0, 8'd0)};
        vecs[21] = '{32'h0022_1825, mk(1, 4'd9,  5'd0,  0, 32'h0,        0, 0, 8'd0)};
        vecs[22] = '{32'h0022_1826, mk(1, 4'd10, 5'd0,  0, 32'h0,        0, 0, 8'd0)};
        vecs[23] = '{32'h2422_0005, mk(1, 4'd6,  5'd0,  1, 32'h0000_0005, 1, 0, 8'd0)};

        // Reset state
        #2;
        rst_n = 1'b0;
        #10;
        q_a.push_back(bub(1'b0, 8'd0));
        q_b.push_back(bub(1'b0, 8'd0));
        chk(0, "reset_state");
        chk(1, "reset_state");
        rst_n = 1'b1;
        cycle();

        // Table-driven decode
        for (int i = 0; i < c_NVEC; i++) begin
            drive(1'b1, vecs[i].instr, 1'b0, 1'b0, 1'b0);
            q_a.push_back(vecs[i].exp);
            q_b.push_back(vecs[i].exp);
            cycle();
            chk(0, $sformatf("vec%0d", i));
            chk(1, $sformatf("vec%0d", i));
        end

        // Idle cycle gives a bubble
        drive(1'b0, c_ADDU, 1'b0, 1'b0, 1'b0);
        q_a.push_back(bub(1'b0, 8'd0));
        cycle();
        chk(0, "idle_bubble");

        // SRA then three stalled cycles: result held for four cycles
        drive(1'b1, c_SRA, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            q_a.push_back(mk(1, 4'd2, 5'd2, 0, 32'h0, 0, 0, 8'd0));
            cycle();
            chk(0, $sformatf("sra_hold%0d", i));
            drive(1'b1, c_ADDU, 1'b1, 1'b0, 1'b0);
        end
        drive(1'b1, c_ADDU, 1'b0, 1'b0, 1'b0);
        q_a.push_back(mk(1, 4'd6, 5'd0, 0, 32'h0, 0, 0, 8'd0));
        cycle();
        chk(0, "stall_release");

        // Illegal handling: sticky halts, non-sticky only flags
        drive(1'b1, c_ILLEGAL, 1'b0, 1'b0, 1'b0);
        q_a.push_back(bub(1'b1, 8'd1)); q_b.push_back(bub(1'b1, 8'd1));
        cycle(); chk(0, "illegal1"); chk(1, "illegal1");
        q_a.push_back(bub(1'b1, 8'd1)); q_b.push_back(bub(1'b1, 8'd2));
        cycle(); chk(0, "illegal2"); chk(1, "illegal2");
        drive(1'b1, c_ADDU, 1'b0, 1'b0, 1'b0);
        q_a.push_back(bub(1'b1, 8'd1));
        q_b.push_back(mk(1, 4'd6, 5'd0, 0, 32'h0, 0, 1, 8'd2));
        cycle(); chk(0, "halt_legal"); chk(1, "halt_legal");
        drive(1'b1, c_ADDU, 1'b0, 1'b0, 1'b1);
        q_a.push_back(bub(1'b0, 8'd1)); q_b.push_back(bub(1'b0, 8'd2));
        cycle(); chk(0, "clear"); chk(1, "clear");
        drive(1'b1, c_ADDU, 1'b0, 1'b0, 1'b0);
        q_a.push_back(mk(1, 4'd6, 5'd0, 0, 32'h0, 0, 0, 8'd1));
        q_b.push_back(mk(1, 4'd6, 5'd0, 0, 32'h0, 0, 0, 8'd2));
        cycle(); chk(0, "after_clear"); chk(1, "after_clear");

        reset_pulse("reset_run");

        // Saturation: 300 illegal instructions
        drive(1'b1, c_ILLEGAL, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            q_a.push_back(bub(1'b1, 8'd1));
            q_b.push_back(bub(1'b1, (i >= 254) ? 8'd255 : 8'(i + 1)));
            cycle();
            chk(0, $sformatf("sat%0d", i));
            chk(1, $sformatf("sat%0d", i));
        end

        // Flush beats stall with a valid ADDU
        drive(1'b1, c_ADDU, 1'b0, 1'b0, 1'b0);
        q_a.push_back(bub(1'b1, 8'd1));
        q_b.push_back(mk(1, 4'd6, 5'd0, 0, 32'h0, 0, 1, 8'd255));
        cycle(); chk(0, "pre_flush"); chk(1, "pre_flush");
        drive(1'b1, c_ADDU, 1'b1, 1'b1, 1'b0);
        q_a.push_back(bub(1'b1, 8'd1)); q_b.push_back(bub(1'b1, 8'd255));
        cycle(); chk(0, "flush_stall"); chk(1, "flush_stall");

        // Clear is ignored under flush and under stall
        drive(1'b1, c_ILLEGAL, 1'b0, 1'b1, 1'b1);
        q_a.push_back(bub(1'b1, 8'd1)); q_b.push_back(bub(1'b1, 8'd255));
        cycle(); chk(0, "flush_clear"); chk(1, "flush_clear");
        drive(1'b0, c_ADDU, 1'b1, 1'b0, 1'b1);
        q_a.push_back(bub(1'b1, 8'd1)); q_b.push_back(bub(1'b1, 8'd255));
        cycle(); chk(0, "stall_clear"); chk(1, "stall_clear");
        drive(1'b0, c_ADDU, 1'b0, 1'b0, 1'b1);
        q_a.push_back(bub(1'b0, 8'd1)); q_b.push_back(bub(1'b0, 8'd255));
        cycle(); chk(0, "clear_keep_cnt"); chk(1, "clear_keep_cnt");

        // Back into HALT, then asynchronous reset between edges
        drive(1'b1, c_ILLEGAL, 1'b0, 1'b0, 1'b0);
        q_a.push_back(bub(1'b1, 8'd2)); q_b.push_back(bub(1'b1, 8'd255));
        cycle(); chk(0, "rehalt"); chk(1, "rehalt");
        drive(1'b1, c_ADDU, 1'b0, 1'b0, 1'b0);
        q_a.push_back(bub(1'b1, 8'd2));
        q_b.push_back(mk(1, 4'd6, 5'd0, 0, 32'h0, 0, 1, 8'd255));
        cycle(); chk(0, "halted_addu"); chk(1, "halted_addu");
        reset_pulse("reset_in_halt");
        q_a.push_back(mk(1, 4'd6, 5'd0, 0, 32'h0, 0, 0, 8'd0));
        q_b.push_back(mk(1, 4'd6, 5'd0, 0, 32'h0, 0, 0, 8'd0));
        cycle(); chk(0, "resume"); chk(1, "resume");

        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
